// File: rtl/riscv_tag_mode_stage_pkg.sv
// Shared opcodes, ALU tag modes and tag-propagation classes for the tag-mode stage.
package riscv_tag_mode_stage_pkg;

  localparam int unsigned ALU_MODE_WIDTH = 2;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD = 2'b00;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_MULT = 7'h01;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    TAG_CLASS_JUMP       = 3'd0,
    TAG_CLASS_BRANCH     = 3'd1,
    TAG_CLASS_LOADSTORE  = 3'd2,
    TAG_CLASS_INTEGER    = 3'd3,
    TAG_CLASS_SHIFT      = 3'd4,
    TAG_CLASS_COMPARISON = 3'd5,
    TAG_CLASS_LOGICAL    = 3'd6,
    TAG_CLASS_NONE       = 3'd7
  } tag_class_e;

endpackage

// File: rtl/riscv_tag_mode_stage_class_decode.sv
// Combinational instruction-to-tag-class decoder; classes that do not fit
// in NUM_CLASSES fold into the last (NONE) class.
module riscv_tag_class_decode
  import riscv_tag_mode_stage_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 8
) (
  input  logic [31:0]                      instr_i,
  output logic [$clog2(NUM_CLASSES)-1:0]   class_o
);

  localparam int unsigned CLS_W = $clog2(NUM_CLASSES);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  tag_class_e cls;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    cls = TAG_CLASS_NONE;
    case (opcode)
      OPCODE_JAL, OPCODE_JALR:                 cls = TAG_CLASS_JUMP;
      OPCODE_BRANCH:                           cls = TAG_CLASS_BRANCH;
      OPCODE_STORE, OPCODE_LUI, OPCODE_AUIPC:  cls = TAG_CLASS_LOADSTORE;
      OPCODE_OPIMM: begin
        case (funct3)
          3'b000:                 cls = TAG_CLASS_INTEGER;
          3'b010, 3'b011:         cls = TAG_CLASS_COMPARISON;
          3'b100, 3'b110, 3'b111: cls = TAG_CLASS_LOGICAL;
          3'b001: cls = (funct7 == FUNCT7_BASE) ? TAG_CLASS_SHIFT : TAG_CLASS_NONE;
          3'b101: cls = (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT)
                        ? TAG_CLASS_SHIFT : TAG_CLASS_NONE;
          default: cls = TAG_CLASS_NONE;
        endcase
      end
      OPCODE_OP: begin
        // M-extension ops all share funct7 0x01 and count as integer
        if (funct7 == FUNCT7_MULT) begin
          cls = TAG_CLASS_INTEGER;
        end else if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            3'b000:                 cls = TAG_CLASS_INTEGER;
            3'b001, 3'b101:         cls = TAG_CLASS_SHIFT;
            3'b010, 3'b011:         cls = TAG_CLASS_COMPARISON;
            3'b100, 3'b110, 3'b111: cls = TAG_CLASS_LOGICAL;
            default:                cls = TAG_CLASS_NONE;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          case (funct3)
            3'b000:  cls = TAG_CLASS_INTEGER;
            3'b101:  cls = TAG_CLASS_SHIFT;
            default: cls = TAG_CLASS_NONE;
          endcase
        end
      end
      default: cls = TAG_CLASS_NONE;
    endcase
  end

  assign class_o = (32'(cls) >= NUM_CLASSES - 1) ? CLS_W'(NUM_CLASSES - 1) : CLS_W'(cls);

endmodule

// File: rtl/riscv_tag_mode_stage.sv
// Registered tag-mode stage: class decode, TPR MODE lookup, valid/ready hand-off to EX,
// deferred TPR writes. Optional per-class retire counters under RISCV_TAG_MODE_CNT_EN.
module riscv_tag_mode_stage
  import riscv_tag_mode_stage_pkg::*;
#(
  parameter int unsigned TAG_MODE_WIDTH = 2,
  parameter int unsigned NUM_CLASSES    = 8,
  parameter logic [31:0] TPR_RST        = 32'h0,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [31:0]                      instr_rdata_i,
  input  logic                             instr_valid_i,
  output logic                             instr_ready_o,
  input  logic                             ex_ready_i,
  input  logic                             flush_i,
  input  logic [31:0]                      tpr_wdata_i,
  input  logic                             tpr_we_i,
  output logic                             tpr_pending_o,
  output logic [TAG_MODE_WIDTH-1:0]        mode_o,
  output logic [$clog2(NUM_CLASSES)-1:0]   mode_class_o,
  output logic                             mode_valid_o,
  input  logic [$clog2(NUM_CLASSES)-1:0]   cnt_sel_i,
  input  logic                             cnt_clr_i,
  output logic [CNT_WIDTH-1:0]             cnt_o
);

  localparam int unsigned CLS_W = $clog2(NUM_CLASSES);
  localparam logic [CLS_W-1:0]          CLS_NONE   = CLS_W'(NUM_CLASSES - 1);
  localparam logic [TAG_MODE_WIDTH-1:0] MODE_OLD   = TAG_MODE_WIDTH'(ALU_MODE_OLD);
  localparam logic [0:0]                TPR_IDLE    = 1'b0;
  localparam logic [0:0]                TPR_PENDING = 1'b1;

  if ((NUM_CLASSES - 1) * TAG_MODE_WIDTH > 32) begin : g_tpr_fit_check
    $error("riscv_tag_mode_stage: (NUM_CLASSES-1)*TAG_MODE_WIDTH exceeds 32 TPR bits");
  end

  logic                      mode_valid_q, mode_valid_d;
  logic [TAG_MODE_WIDTH-1:0] mode_q, mode_d;
  logic [CLS_W-1:0]          class_q, class_d;
  logic [31:0]               tpr_active_q, tpr_active_d;
  logic [31:0]               tpr_shadow_q, tpr_shadow_d;
  logic [0:0]                tpr_state_q, tpr_state_d;

  logic [CLS_W-1:0]          dec_class;
  logic [TAG_MODE_WIDTH-1:0] lookup_mode;
  logic                      stall;
  logic                      accept;

  riscv_tag_class_decode #(
    .NUM_CLASSES (NUM_CLASSES)
  ) u_class_decode (
    .instr_i (instr_rdata_i),
    .class_o (dec_class)
  );

  assign stall         = mode_valid_q && !ex_ready_i;
  assign instr_ready_o = !mode_valid_q || ex_ready_i;
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  // MODE field of the decoded class, taken from the currently active TPR
  assign lookup_mode = (dec_class == CLS_NONE) ? MODE_OLD
                     : TAG_MODE_WIDTH'(tpr_active_q >> (32'(dec_class) * TAG_MODE_WIDTH));

  always_comb begin
    mode_valid_d = mode_valid_q;
    mode_d       = mode_q;
    class_d      = class_q;
    tpr_active_d = tpr_active_q;
    tpr_shadow_d = tpr_shadow_q;
    tpr_state_d  = tpr_state_q;

    if (flush_i) begin
      mode_valid_d = 1'b0;
    end else if (accept) begin
      mode_valid_d = 1'b1;
      mode_d       = lookup_mode;
      class_d      = dec_class;
    end else if (ex_ready_i) begin
      mode_valid_d = 1'b0;
    end

    // A write during a stall is parked so the held entry's mode never changes under EX
    if (tpr_state_q == TPR_IDLE) begin
      if (tpr_we_i) begin
        if (stall) begin
          tpr_shadow_d = tpr_wdata_i;
          tpr_state_d  = TPR_PENDING;
        end else begin
          tpr_active_d = tpr_wdata_i;
        end
      end
    end else begin
      if (ex_ready_i || flush_i) begin
        tpr_active_d = tpr_we_i ? tpr_wdata_i : tpr_shadow_q;
        tpr_state_d  = TPR_IDLE;
      end else if (tpr_we_i) begin
        tpr_shadow_d = tpr_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_valid_q <= 1'b0;
      mode_q       <= MODE_OLD;
      class_q      <= CLS_NONE;
      tpr_active_q <= TPR_RST;
      tpr_shadow_q <= TPR_RST;
      tpr_state_q  <= TPR_IDLE;
    end else begin
      mode_valid_q <= mode_valid_d;
      mode_q       <= mode_d;
      class_q      <= class_d;
      tpr_active_q <= tpr_active_d;
      tpr_shadow_q <= tpr_shadow_d;
      tpr_state_q  <= tpr_state_d;
    end
  end

  assign mode_valid_o  = mode_valid_q;
  assign mode_o        = mode_q;
  assign mode_class_o  = class_q;
  assign tpr_pending_o = (tpr_state_q == TPR_PENDING);

`ifdef RISCV_TAG_MODE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CLASSES];
  logic                 retire;

  assign retire = mode_valid_q && ex_ready_i && !flush_i;

  // Saturating per-class retire counters; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_q[i] <= '0;
    end else if (cnt_clr_i) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) cnt_q[i] <= '0;
    end else if (retire) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        if (class_q == CLS_W'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign cnt_o = (32'(cnt_sel_i) < NUM_CLASSES) ? cnt_q[cnt_sel_i] : '0;
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = ^{cnt_sel_i, cnt_clr_i};
  assign cnt_o             = '0;
`endif

endmodule

// File: tb/tb_riscv_tag_mode_stage.sv
// Scoreboard bench for riscv_tag_mode_stage: driver pushes hand-computed {class,mode}
// expectations, a negedge monitor pops and compares on every retire.
module tb_riscv_tag_mode_stage;

`ifdef RISCV_TAG_MODE_CNT_EN
  localparam int unsigned TB_CNT_W = 4;
`else
  localparam int unsigned TB_CNT_W = 16;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         instr_rdata = 32'h0;
  logic                instr_valid = 1'b0;
  logic                instr_ready;
  logic                ex_ready = 1'b0;
  logic                flush = 1'b0;
  logic [31:0]         tpr_wdata = 32'h0;
  logic                tpr_we = 1'b0;
  logic                tpr_pending;
  logic [1:0]          mode;
  logic [2:0]          mode_class;
  logic                mode_valid;
  logic [2:0]          cnt_sel = 3'd0;
  logic                cnt_clr = 1'b0;
  logic [TB_CNT_W-1:0] cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_ret   = 0;
  logic [4:0]  sb_q [$];

  riscv_tag_mode_stage #(
    .TAG_MODE_WIDTH (2),
    .NUM_CLASSES    (8),
    .TPR_RST        (32'h0),
    .CNT_WIDTH      (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_rdata_i (instr_rdata),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .ex_ready_i    (ex_ready),
    .flush_i       (flush),
    .tpr_wdata_i   (tpr_wdata),
    .tpr_we_i      (tpr_we),
    .tpr_pending_o (tpr_pending),
    .mode_o        (mode),
    .mode_class_o  (mode_class),
    .mode_valid_o  (mode_valid),
    .cnt_sel_i     (cnt_sel),
    .cnt_clr_i     (cnt_clr),
    .cnt_o         (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Retire monitor: every entry EX consumes must match the oldest expectation
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && mode_valid && ex_ready && !flush) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL retire_unexpected: got %0h, expected no retire", {mode_class, mode});
      end else begin
        e = sb_q.pop_front();
        check($sformatf("retire%0d", n_ret), 32'({mode_class, mode}), 32'(e));
      end
      n_ret++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] c, input logic [1:0] m,
                      input logic rdy);
    instr_rdata = ins;
    instr_valid = 1'b1;
    ex_ready    = rdy;
    sb_q.push_back({c, m});
    step();
    instr_valid = 1'b0;
  endtask

  task automatic tpr_write(input logic [31:0] v);
    tpr_wdata = v;
    tpr_we    = 1'b1;
    step();
    tpr_we    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(mode_valid),  32'd0);
    check({tag, "_mode"},    32'(mode),        32'd0);
    check({tag, "_class"},   32'(mode_class),  32'd7);
    check({tag, "_pending"}, 32'(tpr_pending), 32'd0);
  endtask

  initial begin
    step();
    step();
    check_reset_outputs("reset");
    check("reset_ready", 32'(instr_ready), 32'd1);
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    step();

    // Basic lookup with TPR 0x80 (class 3 field = 2'b10)
    tpr_write(32'h0000_0080);
    send(32'h0010_0093, 3'd3, 2'b10, 1'b1);  // ADDI
    send(32'h0000_2083, 3'd7, 2'b00, 1'b1);  // LW
    tpr_write(32'h0000_0300);
    send(32'h0010_90B3, 3'd4, 2'b11, 1'b1);  // SLL

    // Full class sweep, TPR fields k0..k6 = 3,2,1,0,3,1,2
    tpr_write(32'h0000_271B);
    send(32'h0000_006F, 3'd0, 2'b11, 1'b1);  // JAL
    send(32'h0000_0063, 3'd1, 2'b10, 1'b1);  // BEQ
    send(32'h0020_A023, 3'd2, 2'b01, 1'b1);  // SW
    send(32'h0000_10B7, 3'd2, 2'b01, 1'b1);  // LUI
    send(32'h0210_80B3, 3'd3, 2'b00, 1'b1);  // MUL
    send(32'h4010_80B3, 3'd3, 2'b00, 1'b1);  // SUB
    send(32'h4010_5093, 3'd4, 2'b11, 1'b1);  // SRAI
    send(32'h0010_B093, 3'd5, 2'b01, 1'b1);  // SLTIU
    send(32'h0010_C093, 3'd6, 2'b10, 1'b1);  // XORI
    send(32'h0010_E0B3, 3'd6, 2'b10, 1'b1);  // OR
    send(32'h4010_9093, 3'd7, 2'b00, 1'b1);  // SLLI bad funct7
    send(32'h4010_90B3, 3'd7, 2'b00, 1'b1);  // OP f7=0x20 f3=001
    send(32'h0000_000F, 3'd7, 2'b00, 1'b1);  // FENCE
    step();

    // Stall with a deferred TPR write
    tpr_write(32'h0);
    step();
    send(32'h0000_006F, 3'd0, 2'b00, 1'b0);
    check("stall_valid", 32'(mode_valid), 32'd1);
    check("stall_ready", 32'(instr_ready), 32'd0);
    tpr_write(32'h3);
    check("stall_pending", 32'(tpr_pending), 32'd1);
    step();
    step();
    check("stall_mode_held", 32'({mode_class, mode}), 32'({3'd0, 2'b00}));
    check("stall_still_pending", 32'(tpr_pending), 32'd1);
    ex_ready = 1'b1;
    step();
    check("release_pending", 32'(tpr_pending), 32'd0);
    check("release_valid", 32'(mode_valid), 32'd0);
    send(32'h0000_006F, 3'd0, 2'b11, 1'b1);
    step();

    // Flush of a stalled entry with two buffered writes (last wins)
    send(32'h0000_006F, 3'd0, 2'b11, 1'b0);
    tpr_write(32'h5);
    tpr_write(32'hC);
    check("flush_pre_pending", 32'(tpr_pending), 32'd1);
    flush       = 1'b1;
    instr_valid = 1'b1;
    instr_rdata = 32'h0000_0063;
    void'(sb_q.pop_back());
    step();
    flush       = 1'b0;
    instr_valid = 1'b0;
    check("flush_valid", 32'(mode_valid), 32'd0);
    check("flush_pending", 32'(tpr_pending), 32'd0);
    send(32'h0000_006F, 3'd0, 2'b00, 1'b1);
    send(32'h0000_0063, 3'd1, 2'b11, 1'b1);
    step();

    // Flush overrides a same-cycle accept while idle
    flush       = 1'b1;
    instr_valid = 1'b1;
    instr_rdata = 32'h0010_0093;
    step();
    flush       = 1'b0;
    instr_valid = 1'b0;
    check("flush_accept_valid", 32'(mode_valid), 32'd0);

    // Asynchronous reset while stalled and PENDING
    send(32'h0000_2083, 3'd7, 2'b00, 1'b0);
    tpr_write(32'hFFFF_FFFF);
    check("prerst_pending", 32'(tpr_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    step();
    send(32'h0000_006F, 3'd0, 2'b00, 1'b1);
    send(32'h0000_0063, 3'd1, 2'b00, 1'b1);
    step();

`ifdef RISCV_TAG_MODE_CNT_EN
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) send(32'h0000_0063, 3'd1, 2'b00, 1'b1);
    step();
    cnt_sel = 3'd1;
    #1;
    check("cnt_branch_sat", 32'(cnt), 32'hF);
    send(32'h0000_006F, 3'd0, 2'b00, 1'b0);
    flush = 1'b1;
    void'(sb_q.pop_back());
    step();
    flush   = 1'b0;
    cnt_sel = 3'd0;
    #1;
    check("cnt_flush_not_counted", 32'(cnt), 32'd0);
    ex_ready = 1'b1;
    send(32'h0000_006F, 3'd0, 2'b00, 1'b1);
    step();
    check("cnt_jump_one", 32'(cnt), 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    cnt_sel = 3'd1;
    #1;
    check("cnt_clear", 32'(cnt), 32'd0);
`else
    cnt_sel = 3'd1;
    #1;
    check("cnt_tied_zero", 32'(cnt), 32'd0);
`endif

    step();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
